// File: rtl/muller_c_formal_harness.sv
// Synchronous Muller C-element network (2-in and 3-in first level, gated 3-in second level)
// with sticky cover flags, a saturating C2 transition counter and an independent shadow check.

module muller_c_elem #(
  parameter int N = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] in,
  output logic         q,
  output logic         q_next
);

  always_comb begin
    q_next = q;
    if (&in)
      q_next = 1'b1;
    else if (~|in)
      q_next = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset)
      q <= 1'b0;
    else
      q <= q_next;
  end

endmodule

module muller_c_formal_harness #(
  parameter int CNT_W = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [5:0]       io_in,
  output logic [5:0]       io_out,
  output logic [5:0]       io_oeb,
  output logic [5:0]       cov_o,
  output logic [CNT_W-1:0] trans_cnt_o,
  output logic             err_o
);

  logic c0_q, c1_q, c2_q;
  logic c0_next, c1_next, c2_next;
  logic [2:0] c2_in;

  // C2 sees the pre-edge first-level registers, hence its one-cycle lag.
  assign c2_in = {c0_q, c1_q, io_in[5]};

  muller_c_elem #(.N(2)) u_c0 (
    .clock  (wb_clk_i),
    .reset  (wb_rst_i),
    .in     (io_in[1:0]),
    .q      (c0_q),
    .q_next (c0_next)
  );

  muller_c_elem #(.N(3)) u_c1 (
    .clock  (wb_clk_i),
    .reset  (wb_rst_i),
    .in     (io_in[4:2]),
    .q      (c1_q),
    .q_next (c1_next)
  );

  muller_c_elem #(.N(3)) u_c2 (
    .clock  (wb_clk_i),
    .reset  (wb_rst_i),
    .in     (c2_in),
    .q      (c2_q),
    .q_next (c2_next)
  );

  assign io_out = {3'b000, c2_q, c1_q, c0_q};
  assign io_oeb = 6'b000000;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cov_o <= '0;
    end else begin
      cov_o[0] <= cov_o[0] | (~c0_q &  c0_next);
      cov_o[1] <= cov_o[1] | ( c0_q & ~c0_next);
      cov_o[2] <= cov_o[2] | (~c1_q &  c1_next);
      cov_o[3] <= cov_o[3] | ( c1_q & ~c1_next);
      cov_o[4] <= cov_o[4] | (~c2_q &  c2_next);
      cov_o[5] <= cov_o[5] | ( c2_q & ~c2_next);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      trans_cnt_o <= '0;
    else if ((c2_next != c2_q) && (trans_cnt_o != {CNT_W{1'b1}}))
      trans_cnt_o <= trans_cnt_o + 1'b1;
  end

  // Shadow check: snapshot each element's inputs and pre-edge value, then judge
  // the resulting register change one edge later without reusing the next-state logic.
  logic       chk_vld;
  logic [1:0] s0_in;
  logic [2:0] s1_in, s2_in;
  logic [2:0] s_q;
  logic       bad0, bad1, bad2;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      chk_vld <= 1'b0;
      s0_in   <= '0;
      s1_in   <= '0;
      s2_in   <= '0;
      s_q     <= '0;
    end else begin
      chk_vld <= 1'b1;
      s0_in   <= io_in[1:0];
      s1_in   <= io_in[4:2];
      s2_in   <= c2_in;
      s_q     <= {c2_q, c1_q, c0_q};
    end
  end

  always_comb begin
    bad0 = 1'b0;
    bad1 = 1'b0;
    bad2 = 1'b0;
    if (c0_q != s_q[0])
      bad0 = !((s0_in == 2'b11 && c0_q) || (s0_in == 2'b00 && !c0_q));
    if (c1_q != s_q[1])
      bad1 = !((s1_in == 3'b111 && c1_q) || (s1_in == 3'b000 && !c1_q));
    if (c2_q != s_q[2])
      bad2 = !((s2_in == 3'b111 && c2_q) || (s2_in == 3'b000 && !c2_q));
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      err_o <= 1'b0;
    else if (chk_vld && (bad0 || bad1 || bad2))
      err_o <= 1'b1;
  end

endmodule

// File: tb/tb_muller_c_formal_harness.sv
// Directed plus random stimulus against a per-edge behavioural model of the C-element network.

module tb_muller_c_formal_harness;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] io_in;
  logic [5:0] io_out, io_oeb, cov_o;
  logic [7:0] trans_cnt_o;
  logic       err_o;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int m_c0, m_c1, m_c2, m_cnt;
  int m_cov[6];

  always #5 clk = ~clk;

  muller_c_formal_harness #(.CNT_W(8)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .io_in       (io_in),
    .io_out      (io_out),
    .io_oeb      (io_oeb),
    .cov_o       (cov_o),
    .trans_cnt_o (trans_cnt_o),
    .err_o       (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int c_rule(input int ones, input int n, input int q);
    if (ones == n) return 1;
    if (ones == 0) return 0;
    return q;
  endfunction

  task automatic model_edge(input logic r, input logic [5:0] v);
    int n0, n1, n2;
    if (r) begin
      m_c0 = 0; m_c1 = 0; m_c2 = 0; m_cnt = 0;
      for (int i = 0; i < 6; i++) m_cov[i] = 0;
      return;
    end
    n0 = c_rule(v[0] + v[1], 2, m_c0);
    n1 = c_rule(v[2] + v[3] + v[4], 3, m_c1);
    n2 = c_rule(m_c0 + m_c1 + v[5], 3, m_c2);
    if (n0 > m_c0) m_cov[0] = 1;
    if (n0 < m_c0) m_cov[1] = 1;
    if (n1 > m_c1) m_cov[2] = 1;
    if (n1 < m_c1) m_cov[3] = 1;
    if (n2 > m_c2) m_cov[4] = 1;
    if (n2 < m_c2) m_cov[5] = 1;
    if (n2 != m_c2 && m_cnt < 255) m_cnt++;
    m_c0 = n0; m_c1 = n1; m_c2 = n2;
  endtask

  function automatic logic [5:0] model_cov();
    logic [5:0] c;
    for (int i = 0; i < 6; i++) c[i] = (m_cov[i] != 0);
    return c;
  endfunction

  // one clock: drive, clock, update model, compare #1 after the edge
  task automatic cyc(input logic r, input logic [5:0] v, input string tag);
    rst   = r;
    io_in = v;
    @(posedge clk);
    model_edge(r, v);
    #1;
    chk({tag, ".io_out"}, {26'd0, io_out}, m_c2 * 4 + m_c1 * 2 + m_c0);
    chk({tag, ".cov"}, {26'd0, cov_o}, {26'd0, model_cov()});
    chk({tag, ".cnt"}, {24'd0, trans_cnt_o}, m_cnt);
    chk({tag, ".err"}, {31'd0, err_o}, 0);
    chk({tag, ".oeb"}, {26'd0, io_oeb}, 0);
  endtask

  initial begin
    m_c0 = 0; m_c1 = 0; m_c2 = 0; m_cnt = 0;
    for (int i = 0; i < 6; i++) m_cov[i] = 0;
    rst = 1'b1;
    io_in = '0;
    #1;

    // 1: non-unanimous inputs hold everything at zero
    cyc(1'b1, 6'b011001, "rst");
    for (int i = 0; i < 4; i++) cyc(1'b0, 6'b011001, "hold");
    chk("t1.out_zero", {26'd0, io_out}, 0);

    // 2: all ones
    cyc(1'b1, 6'b111111, "rst");
    cyc(1'b0, 6'b111111, "t2e1");
    chk("t2.e1", {26'd0, io_out}, 32'b011);
    cyc(1'b0, 6'b111111, "t2e2");
    chk("t2.e2", {26'd0, io_out}, 32'b111);
    chk("t2.cov", {26'd0, cov_o}, 32'b010101);
    chk("t2.cnt", {24'd0, trans_cnt_o}, 1);

    // 3: C1 falls, C0/C2 hold
    cyc(1'b0, 6'b000001, "t3");
    chk("t3.out", {26'd0, io_out}, 32'b101);
    chk("t3.cov3", {31'd0, cov_o[3]}, 1);
    chk("t3.cnt", {24'd0, trans_cnt_o}, 1);

    // 4: toggle to saturation
    for (int i = 0; i < 600; i++)
      cyc(1'b0, ((i / 2) % 2 == 0) ? 6'b000000 : 6'b111111, "tog");
    chk("t4.sat", {24'd0, trans_cnt_o}, 255);

    // 5: mid-operation reset
    cyc(1'b0, 6'b111111, "t5a");
    cyc(1'b0, 6'b111111, "t5b");
    cyc(1'b1, 6'b111111, "t5rst");
    chk("t5.clr", {26'd0, io_out}, 0);
    chk("t5.cov_clr", {26'd0, cov_o}, 0);
    cyc(1'b0, 6'b111111, "t5post");
    chk("t5.post", {26'd0, io_out}, 32'b011);
    chk("t5.cov_post", {26'd0, cov_o}, 32'b000101);

    // 6: gate holds C2 low, releasing it sets C2 one edge later
    cyc(1'b0, 6'b011111, "t6g0");
    cyc(1'b0, 6'b011111, "t6g0b");
    chk("t6.held", {31'd0, io_out[2]}, 0);
    cyc(1'b0, 6'b111111, "t6g1");
    chk("t6.set", {31'd0, io_out[2]}, 1);

    // random: mostly biased toward unanimous groups, occasional reset
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] v;
      v = 6'($urandom);
      if ($urandom_range(0, 2) == 0) v[1:0] = {2{v[0]}};
      if ($urandom_range(0, 2) == 0) v[4:2] = {3{v[2]}};
      cyc($urandom_range(0, 199) == 0, v, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
